// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared constants and helpers for the clock divider bank.
//   CNT_W_DEF     : default counter / half-period register width
//   DEF_HALF_DEF  : default reset half-period (25 MHz -> 1 kHz)
//   half_from_hz  : constant function giving the half-period for a target rate
//   sel_width     : channel-select width, never less than one bit
// Optional feature macro used by the bank: CLK_DIV_SYNC_EN.
// -----------------------------------------------------------------------------
package clk_div_pkg;

  localparam int unsigned CNT_W_DEF    = 27;
  localparam int unsigned DEF_HALF_DEF = 12500;

  // Half-period in system clocks for a wanted output frequency.
  function automatic longint unsigned half_from_hz(input longint unsigned clk_hz,
                                                   input longint unsigned out_hz);
    return clk_hz / (64'd2 * out_hz);
  endfunction

  // A single-channel bank still gets a one-bit select port.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// -----------------------------------------------------------------------------
// clk_div_ch
// One programmable divider channel: counter, active and shadow half-period
// registers, pending flag, tick strobe and 50 % square-wave output.
// Ports:
//   clk_i, rst_n   : system clock, async active-low reset
//   en_i           : run enable
//   sync_i         : realign request (tied low when the bank is built without
//                    CLK_DIV_SYNC_EN)
//   we_i, data_i   : decoded half-period write for this channel
//   tick_o         : one-cycle strobe at the end of each half-period
//   clk_o          : divided clock, period 2*max(H,1)
// -----------------------------------------------------------------------------
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned DEF_HALF = DEF_HALF_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] data_i,
  output logic             tick_o,
  output logic             clk_o
);

  localparam logic [CNT_W-1:0] DEF_HALF_C = CNT_W'(DEF_HALF);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             tick_q, tick_d;
  logic             clk_q, clk_d;
  logic [CNT_W-1:0] heff_m1;
  logic             terminal;
  logic             boundary;

  // Next-state logic. H=0 is treated as H=1 by clamping the terminal value at
  // zero, so the counter never has to wrap. The active half-period only
  // changes at a boundary (terminal cycle, disabled, or sync), and a write in
  // that same cycle takes effect immediately so it governs the next half.
  always_comb begin
    heff_m1   = (active_q == '0) ? '0 : active_q - CNT_W'(1);
    terminal  = en_i && (cnt_q == heff_m1);
    boundary  = terminal || !en_i || sync_i;

    cnt_d     = cnt_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    tick_d    = 1'b0;
    clk_d     = clk_q;

    if (we_i) begin
      shadow_d  = data_i;
      pending_d = 1'b1;
    end

    if (boundary) begin
      if (we_i) begin
        active_d  = data_i;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end

    if (sync_i) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (!en_i) begin
      cnt_d = '0;
    end else if (terminal) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      clk_d  = ~clk_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      active_q  <= DEF_HALF_C;
      shadow_q  <= DEF_HALF_C;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      clk_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
      clk_q     <= clk_d;
    end
  end

  assign tick_o = tick_q;
  assign clk_o  = clk_q;

endmodule

// File: rtl/clk_div_bank.sv
// -----------------------------------------------------------------------------
// clk_div_bank
// Bank of NUM_CH independent programmable clock dividers sharing one system
// clock. Each channel produces a one-cycle tick per half-period and a 50 %
// square wave; half-periods are rewritten at runtime through a small write
// port and retimed at period boundaries.
// Ports:
//   clk_i, rst_n         : system clock, async active-low reset
//   en_i[NUM_CH]         : per-channel run enable
//   div_we_i             : half-period write strobe
//   div_sel_i            : target channel (out-of-range writes are dropped)
//   div_data_i[CNT_W]    : new half-period value
//   tick_o[NUM_CH]       : tick strobes
//   clk_o[NUM_CH]        : divided clocks
//   sync_i               : realign all channels (only with CLK_DIV_SYNC_EN)
// Optional feature macro: CLK_DIV_SYNC_EN.
// -----------------------------------------------------------------------------
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned DEF_HALF = DEF_HALF_DEF,
  localparam int unsigned SEL_W   = sel_width(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              div_we_i,
  input  logic [SEL_W-1:0]  div_sel_i,
  input  logic [CNT_W-1:0]  div_data_i,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] clk_o
`ifdef CLK_DIV_SYNC_EN
  ,
  input  logic              sync_i
`endif
);

  logic sync_w;

`ifdef CLK_DIV_SYNC_EN
  assign sync_w = sync_i;
`else
  assign sync_w = 1'b0;
`endif

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      logic ch_we;

      // A select value beyond NUM_CH-1 matches no channel and is dropped.
      assign ch_we = div_we_i && (div_sel_i == SEL_W'(i));

      clk_div_ch #(
        .CNT_W   (CNT_W),
        .DEF_HALF(DEF_HALF)
      ) u_ch (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .en_i  (en_i[i]),
        .sync_i(sync_w),
        .we_i  (ch_we),
        .data_i(div_data_i),
        .tick_o(tick_o[i]),
        .clk_o (clk_o[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clk_div_bank.sv
// -----------------------------------------------------------------------------
// tb_clk_div_bank
// Directed bench for clk_div_bank with NUM_CH=3, CNT_W=8, DEF_HALF=3.
// Three channels leave select value 3 free as an out-of-range target.
// Build with CLK_DIV_SYNC_EN to include the realignment scenario.
// -----------------------------------------------------------------------------
module tb_clk_div_bank;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CNT_W  = 8;

  logic             clk;
  logic             rst_n;
  logic [2:0]       en;
  logic             div_we;
  logic [1:0]       div_sel;
  logic [CNT_W-1:0] div_data;
  logic [2:0]       tick;
  logic [2:0]       clko;
`ifdef CLK_DIV_SYNC_EN
  logic             sync;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  clk_div_bank #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DEF_HALF(3)
  ) dut (
    .clk_i     (clk),
    .rst_n     (rst_n),
    .en_i      (en),
    .div_we_i  (div_we),
    .div_sel_i (div_sel),
    .div_data_i(div_data),
    .tick_o    (tick),
    .clk_o     (clko)
`ifdef CLK_DIV_SYNC_EN
    ,
    .sync_i    (sync)
`endif
  );

  // 10 ns system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset asserted with no clock edge needed: outputs must already be low.
  task automatic test_reset();
    rst_n    = 1'b0;
    en       = 3'b000;
    div_we   = 1'b0;
    div_sel  = 2'd0;
    div_data = '0;
`ifdef CLK_DIV_SYNC_EN
    sync     = 1'b0;
`endif
    #12;
    vec_cnt++;
    if (tick !== 3'b000) begin
      err_cnt++;
      $display("[TB] FAIL reset_tick got %b exp %b", tick, 3'b000);
    end
    vec_cnt++;
    if (clko !== 3'b000) begin
      err_cnt++;
      $display("[TB] FAIL reset_clk got %b exp %b", clko, 3'b000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    en    = 3'b111;
  endtask

  // H=3 on all channels: tick at edges 3,6,9,12 and clk_o period 6.
  task automatic test_default_div();
    logic [2:0] exp_tick;
    logic [2:0] exp_clk;
    for (int c = 1; c <= 12; c++) begin
      step();
      exp_tick = (c % 3 == 0) ? 3'b111 : 3'b000;
      exp_clk  = (((c / 3) % 2) == 1) ? 3'b111 : 3'b000;
      vec_cnt++;
      if (tick !== exp_tick) begin
        err_cnt++;
        $display("[TB] FAIL default_tick c=%0d got %b exp %b", c, tick, exp_tick);
      end
      vec_cnt++;
      if (clko !== exp_clk) begin
        err_cnt++;
        $display("[TB] FAIL default_clk c=%0d got %b exp %b", c, clko, exp_clk);
      end
    end
  endtask

  // ch0 gets H=0 and ch1 gets H=1 while disabled; both divide by two.
  task automatic test_h0_h1();
    logic [2:0] exp_clk;
    en = 3'b000;
    step();
    vec_cnt++;
    if (tick !== 3'b000) begin
      err_cnt++;
      $display("[TB] FAIL h01_disabled_tick got %b exp %b", tick, 3'b000);
    end
    vec_cnt++;
    if (clko !== 3'b000) begin
      err_cnt++;
      $display("[TB] FAIL h01_disabled_clk got %b exp %b", clko, 3'b000);
    end
    div_we   = 1'b1;
    div_sel  = 2'd0;
    div_data = 8'd0;
    step();
    div_sel  = 2'd1;
    div_data = 8'd1;
    step();
    div_we = 1'b0;
    en     = 3'b011;
    for (int c = 1; c <= 6; c++) begin
      step();
      exp_clk = (c % 2 == 1) ? 3'b011 : 3'b000;
      vec_cnt++;
      if (tick !== 3'b011) begin
        err_cnt++;
        $display("[TB] FAIL h01_tick c=%0d got %b exp %b", c, tick, 3'b011);
      end
      vec_cnt++;
      if (clko !== exp_clk) begin
        err_cnt++;
        $display("[TB] FAIL h01_clk c=%0d got %b exp %b", c, clko, exp_clk);
      end
    end
  endtask

  // ch2 at H=3, write H=5 at cnt=1: current half ends at edge 3, next at 8.
  task automatic test_write_mid();
    logic [2:0] exp_tick;
    logic [2:0] exp_clk;
    en       = 3'b000;
    div_we   = 1'b1;
    div_sel  = 2'd0;
    div_data = 8'd3;
    step();
    div_sel = 2'd1;
    step();
    div_we = 1'b0;
    en     = 3'b100;
    for (int e = 1; e <= 13; e++) begin
      div_we   = (e == 2);
      div_sel  = 2'd2;
      div_data = 8'd5;
      step();
      exp_tick = (e == 3 || e == 8 || e == 13) ? 3'b100 : 3'b000;
      exp_clk  = ((e >= 3 && e <= 7) || e == 13) ? 3'b100 : 3'b000;
      vec_cnt++;
      if (tick !== exp_tick) begin
        err_cnt++;
        $display("[TB] FAIL mid_tick e=%0d got %b exp %b", e, tick, exp_tick);
      end
      vec_cnt++;
      if (clko !== exp_clk) begin
        err_cnt++;
        $display("[TB] FAIL mid_clk e=%0d got %b exp %b", e, clko, exp_clk);
      end
    end
    div_we = 1'b0;
  endtask

  // Write on the terminal cycle (H=3), then writes 7 and 4 before the next
  // boundary: 4 wins. Ticks at k=5 (end of H=5), 8 (H=3), 12 (H=4).
  task automatic test_terminal_write();
    logic [2:0] exp_tick;
    logic [2:0] exp_clk;
    for (int k = 1; k <= 12; k++) begin
      div_we   = (k == 5 || k == 6 || k == 7);
      div_sel  = 2'd2;
      div_data = (k == 5) ? 8'd3 : ((k == 6) ? 8'd7 : 8'd4);
      step();
      exp_tick = (k == 5 || k == 8 || k == 12) ? 3'b100 : 3'b000;
      exp_clk  = (k <= 4 || (k >= 8 && k <= 11)) ? 3'b100 : 3'b000;
      vec_cnt++;
      if (tick !== exp_tick) begin
        err_cnt++;
        $display("[TB] FAIL term_tick k=%0d got %b exp %b", k, tick, exp_tick);
      end
      vec_cnt++;
      if (clko !== exp_clk) begin
        err_cnt++;
        $display("[TB] FAIL term_clk k=%0d got %b exp %b", k, clko, exp_clk);
      end
    end
    div_we = 1'b0;
  endtask

  // ch2 at H=4: disabled for k=7..10 with clk_o high and an out-of-range
  // write issued; restart gives first tick 4 edges after re-enable.
  task automatic test_enable_toggle();
    logic [2:0] exp_tick;
    logic [2:0] exp_clk;
    for (int k = 1; k <= 20; k++) begin
      en       = (k >= 7 && k <= 10) ? 3'b000 : 3'b100;
      div_we   = (k == 8);
      div_sel  = 2'd3;
      div_data = 8'd1;
      step();
      exp_tick = (k == 4 || k == 14 || k == 18) ? 3'b100 : 3'b000;
      exp_clk  = ((k >= 4 && k <= 13) || k >= 18) ? 3'b100 : 3'b000;
      vec_cnt++;
      if (tick !== exp_tick) begin
        err_cnt++;
        $display("[TB] FAIL en_tick k=%0d got %b exp %b", k, tick, exp_tick);
      end
      vec_cnt++;
      if (clko !== exp_clk) begin
        err_cnt++;
        $display("[TB] FAIL en_clk k=%0d got %b exp %b", k, clko, exp_clk);
      end
    end
    div_we  = 1'b0;
    div_sel = 2'd0;
  endtask

  // Reset mid-cycle clears outputs without an edge; afterwards every channel
  // is back at H=3 with ticks at edges 3 and 6.
  task automatic test_reset_async();
    logic [2:0] exp_tick;
    logic [2:0] exp_clk;
    en = 3'b111;
    step();
    step();
    step();
    vec_cnt++;
    if (clko !== 3'b011) begin
      err_cnt++;
      $display("[TB] FAIL pre_reset_clk got %b exp %b", clko, 3'b011);
    end
    vec_cnt++;
    if (tick !== 3'b011) begin
      err_cnt++;
      $display("[TB] FAIL pre_reset_tick got %b exp %b", tick, 3'b011);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (clko !== 3'b000) begin
      err_cnt++;
      $display("[TB] FAIL async_reset_clk got %b exp %b", clko, 3'b000);
    end
    vec_cnt++;
    if (tick !== 3'b000) begin
      err_cnt++;
      $display("[TB] FAIL async_reset_tick got %b exp %b", tick, 3'b000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      exp_tick = (c == 3 || c == 6) ? 3'b111 : 3'b000;
      exp_clk  = (c >= 3 && c <= 5) ? 3'b111 : 3'b000;
      vec_cnt++;
      if (tick !== exp_tick) begin
        err_cnt++;
        $display("[TB] FAIL post_reset_tick c=%0d got %b exp %b", c, tick, exp_tick);
      end
      vec_cnt++;
      if (clko !== exp_clk) begin
        err_cnt++;
        $display("[TB] FAIL post_reset_clk c=%0d got %b exp %b", c, clko, exp_clk);
      end
    end
  endtask

`ifdef CLK_DIV_SYNC_EN
  // ch0 at H=3 and ch1 at H=4 drift apart, then one sync pulse realigns them.
  task automatic test_sync();
    logic [2:0] exp_tick;
    logic [2:0] exp_clk;
    en = 3'b000;
    step();
    div_we   = 1'b1;
    div_sel  = 2'd1;
    div_data = 8'd4;
    step();
    div_we = 1'b0;
    en     = 3'b011;
    for (int k = 1; k <= 5; k++) step();
    vec_cnt++;
    if (clko !== 3'b011) begin
      err_cnt++;
      $display("[TB] FAIL pre_sync_clk got %b exp %b", clko, 3'b011);
    end
    sync = 1'b1;
    step();
    sync = 1'b0;
    vec_cnt++;
    if (clko !== 3'b000) begin
      err_cnt++;
      $display("[TB] FAIL sync_clk got %b exp %b", clko, 3'b000);
    end
    vec_cnt++;
    if (tick !== 3'b000) begin
      err_cnt++;
      $display("[TB] FAIL sync_tick got %b exp %b", tick, 3'b000);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      exp_tick = (k == 3) ? 3'b001 : ((k == 4) ? 3'b010 : 3'b000);
      exp_clk  = (k == 3) ? 3'b001 : ((k == 4) ? 3'b011 : 3'b000);
      vec_cnt++;
      if (tick !== exp_tick) begin
        err_cnt++;
        $display("[TB] FAIL post_sync_tick k=%0d got %b exp %b", k, tick, exp_tick);
      end
      vec_cnt++;
      if (clko !== exp_clk) begin
        err_cnt++;
        $display("[TB] FAIL post_sync_clk k=%0d got %b exp %b", k, clko, exp_clk);
      end
    end
  endtask
`endif

  initial begin
    $display("[TB] clk_div_bank directed test start");
    test_reset();
    test_default_div();
    test_h0_h1();
    test_write_mid();
    test_terminal_write();
    test_enable_toggle();
    test_reset_async();
`ifdef CLK_DIV_SYNC_EN
    test_sync();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised bank of independent programmable clock dividers that generates both a one-cycle tick strobe and a 50 % square wave per channel from the single system clock. It replaces the fixed-ratio 1 kHz display-refresh divider. It serves seven-segment scan, LED blink, debounce sampling and any slow peripheral timing. Divisors are runtime-writable through a small register port, with glitch-free retiming at period boundaries.

## Interface
Parameters:
- NUM_CH, 4, number of divider channels (1..16)
- CNT_W, 27, counter and half-period register width
- DEF_HALF, 12500, reset half-period for every channel (25 MHz -> 1 kHz)

Ports:
- clk_i, in, 1, system clock
- rst_n, in, 1, reset; asynchronous assert, active-low
- en_i, in, NUM_CH, per-channel run enable
- div_we_i, in, 1, half-period write strobe
- div_sel_i, in, $clog2(NUM_CH) (min 1), target channel of write
- div_data_i, in, CNT_W, new half-period value H
- tick_o, out, NUM_CH, one-cycle strobe per half-period
- clk_o, out, NUM_CH, divided square wave (period 2·H cycles)
- sync_i, in, 1, only when CLK_DIV_SYNC_EN defined: realign all channels

## Operation
- Reset (rst_n=0): cnt=0, clk_o=0, tick_o=0, active and shadow half-period = DEF_HALF, pending flag clear.
- Per channel, effective half-period Heff = max(H,1).
- Channel running (en_i=1), each cycle:
  - If cnt == Heff-1: cnt<=0, tick_o<=1, clk_o<=~clk_o.
  - Otherwise cnt<=cnt+1, tick_o<=0.
- Channel disabled (en_i=0):
  - cnt<=0, tick_o<=0, clk_o holds its value.
  - A pending shadow value loads into active immediately.
- Write (div_we_i=1, div_sel_i<NUM_CH): div_data_i goes into the shadow register and sets pending.
  - Out-of-range div_sel_i: write ignored.
- Shadow->active transfer occurs only on the terminal cycle (cnt==Heff-1) or while disabled, so no runt half-period is ever produced.
- Write coincident with terminal cycle: the written value becomes active at that same boundary, i.e. it governs the next half-period.
- Back-to-back writes to one channel before a boundary: last write wins.
- Counter arithmetic is unsigned CNT_W. Comparison against Heff-1 guarantees no wrap; H=0 behaves as H=1 (clk_o = clk_i/2, tick every cycle).

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- en_i sampled high at cycle 0 with cnt=0: first tick_o high in cycle Heff (relative to the first clk_i edge that samples en_i=1), then every Heff cycles.
- tick_o and the clk_o edge appear on the same clk_i edge.
- Enable drop: tick_o low from the next edge; a tick in flight that cycle is not emitted.
- Reset mid-operation: outputs clear asynchronously; first tick after release follows the same Heff latency.

## Configuration
- CLK_DIV_SYNC_EN defined:
  - Adds port sync_i.
  - A cycle with sync_i=1 forces cnt=0, clk_o=0 and tick_o=0 on all channels, and applies pending shadows.
  - sync_i has priority over terminal count and writes to active; a same-cycle write still lands in shadow and applies.
- CLK_DIV_SYNC_EN undefined: no sync_i port; channels are never cross-aligned except by reset.

## Structure
- Package clk_div_pkg holds:
  - CNT_W and DEF_HALF defaults
  - a constant function half_from_hz(clk_hz, out_hz) = clk_hz/(2·out_hz)
  - the channel-select width helper
- Sub-module clk_div_ch implements one channel: counter, active/shadow registers, pending flag, outputs.
- clk_div_bank holds the write decode and instantiates NUM_CH copies via generate.

## Test plan
- Reset, all en_i=1, DEF_HALF=3 override: tick_o every 3 cycles, first in cycle 3; clk_o period 6, 50 % duty.
- H=0 and H=1 written: clk_o toggles every cycle, tick_o constantly high.
- Write H=5 mid-period (cnt=1 of H=3): current half-period finishes at 3 cycles; the next one lasts 5; no glitch on clk_o.
- Write coincident with terminal cycle, and two writes before a boundary: the new/last value governs the following half-period.
- en_i toggled low for 4 cycles then high: clk_o frozen; cnt restarts; first tick Heff cycles after re-enable; out-of-range div_sel_i changes nothing.
- CLK_DIV_SYNC_EN: channels at H=3 and H=4 offset, pulse sync_i: both clk_o=0 next cycle; first ticks at 3 and 4 cycles later; rst_n asserted mid-count clears all outputs asynchronously.
